// File: rtl/byte_serial_add_ctrl.sv
// byte_serial_add_ctrl: byte-serial sequencer around an external registered 8-bit adder.
// Accepts a wide operand pair, feeds the adder one byte per ISSUE/CAPTURE pass (LSB first,
// carry chained through), and presents the assembled sum and final carry downstream.
// Optional feature: define SIGNED_OVF_EN to add the res_ovf signed-overflow output.
module byte_serial_add_ctrl #(
  parameter int unsigned NUM_BYTES = 4,
  localparam int unsigned W = 8 * NUM_BYTES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  input  logic         op_cin,
  output logic [7:0]   add_a,
  output logic [7:0]   add_b,
  output logic         add_cin,
  input  logic [7:0]   add_sum,
  input  logic         add_cout,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
`ifdef SIGNED_OVF_EN
  output logic         res_ovf,
`endif
  output logic         res_cout
);

  // Byte index width; at least one bit so NUM_BYTES=1 still has a legal vector.
  localparam int unsigned KW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [KW-1:0] KLast = KW'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StCapture,
    StDone
  } state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  k_q, k_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           cin_q, cin_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           cout_q, cout_d;
`ifdef SIGNED_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SIGNED_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SIGNED_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state logic: latch operands, step through bytes, capture adder results.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SIGNED_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = op_b;
          cin_d   = op_cin;
          k_d     = '0;
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StCapture;
      end
      StCapture: begin
        sum_d[8*k_q +: 8] = add_sum;
        carry_d           = add_cout;
        if (k_q == KLast) begin
          cout_d  = add_cout;
`ifdef SIGNED_OVF_EN
          // Same-sign operands whose sum flips sign overflowed.
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
`endif
          state_d = StDone;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = StIssue;
        end
      end
      StDone: begin
        if (res_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs: adder operands are held through CAPTURE since k and carry only move at its end.
  always_comb begin
    in_ready  = (state_q == StIdle);
    res_valid = (state_q == StDone);
    add_a     = 8'h00;
    add_b     = 8'h00;
    add_cin   = 1'b0;
    if ((state_q == StIssue) || (state_q == StCapture)) begin
      add_a   = a_q[8*k_q +: 8];
      add_b   = b_q[8*k_q +: 8];
      add_cin = (k_q == '0) ? cin_q : carry_q;
    end
  end

  assign res_sum  = sum_q;
  assign res_cout = cout_q;
`ifdef SIGNED_OVF_EN
  assign res_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_byte_serial_add_ctrl.sv
// Randomized bench for byte_serial_add_ctrl with a behavioural adder and a
// transaction-level reference model (timing from accept cycle, arithmetic on whole words).
module tb_byte_serial_add_ctrl;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         op_cin;
  logic [7:0]   add_a;
  logic [7:0]   add_b;
  logic         add_cin;
  logic [7:0]   add_sum;
  logic         add_cout;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_sum;
  logic         res_cout;
`ifdef SIGNED_OVF_EN
  logic         res_ovf;
`endif

  always #5 clk = ~clk;

  byte_serial_add_ctrl #(.NUM_BYTES(NB)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .op_cin   (op_cin),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_sum  (res_sum),
`ifdef SIGNED_OVF_EN
    .res_ovf  (res_ovf),
`endif
    .res_cout (res_cout)
  );

  // Registered 8-bit adder stage the block drives.
  always_ff @(posedge clk) begin
    if (rst) {add_cout, add_sum} <= 9'd0;
    else     {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_res    = 0;

  // Reference model state
  bit           busy = 1'b0;
  int           t0;
  logic [W-1:0] ma, mb;
  logic         mc;
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  logic         last_ovf  = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [W-1:0] v, input int k);
    return 8'(v >> (8 * k));
  endfunction

  // Carry into byte k of a+b+c, from the low 8k bits of the operands.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input int k);
    longint unsigned m, s;
    if (k == 0) return c;
    m = (64'd1 << (8 * k)) - 64'd1;
    s = (longint'(a) & m) + (longint'(b) & m) + longint'(c);
    return 1'(s >> (8 * k));
  endfunction

  // Drive one cycle of inputs, compare outputs with the model, then advance one clock.
  task automatic cycle(input logic r, input logic iv, input logic rr,
                       input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int rel;
    int k;
    logic [W:0] s;
    logic ovf;
    rst = r; in_valid = iv; res_ready = rr; op_a = a; op_b = b; op_cin = c;
    if (r) begin
      busy = 1'b0; last_sum = '0; last_cout = 1'b0; last_ovf = 1'b0;
    end else if (!busy) begin
      check("idle_in_ready", in_ready, 1);
      check("idle_res_valid", res_valid, 0);
      check("idle_add_a", add_a, 0);
      check("idle_add_b", add_b, 0);
      check("idle_add_cin", add_cin, 0);
      check("idle_res_sum", res_sum, last_sum);
      check("idle_res_cout", res_cout, last_cout);
`ifdef SIGNED_OVF_EN
      check("idle_res_ovf", res_ovf, last_ovf);
`endif
      if (iv) begin
        busy = 1'b1; t0 = cyc; ma = a; mb = b; mc = c;
      end
    end else begin
      rel = cyc - t0;
      check("busy_in_ready", in_ready, 0);
      if (rel <= 2 * NB) begin
        k = (rel - 1) / 2;
        check("busy_res_valid", res_valid, 0);
        check("busy_add_a", add_a, byte_of(ma, k));
        check("busy_add_b", add_b, byte_of(mb, k));
        check("busy_add_cin", add_cin, carry_into(ma, mb, mc, k));
        check("busy_res_cout", res_cout, last_cout);
      end else begin
        s   = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        ovf = (ma[W-1] == mb[W-1]) && (s[W-1] != ma[W-1]);
        check("done_res_valid", res_valid, 1);
        check("done_res_sum", res_sum, s[W-1:0]);
        check("done_res_cout", res_cout, s[W]);
        check("done_add_a", add_a, 0);
        check("done_add_cin", add_cin, 0);
`ifdef SIGNED_OVF_EN
        check("done_res_ovf", res_ovf, ovf);
`endif
        if (rr) begin
          busy = 1'b0; last_sum = s[W-1:0]; last_cout = s[W]; last_ovf = ovf; n_res++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
  endtask

  initial begin
    int res_before;
    logic [W-1:0] ra, rb;
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(2);

    // Carry ripple across one byte
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    idle(10);

    // Full-width carry chain driven from op_cin
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    idle(10);

    // Backpressure: result held 5 cycles while in_valid stays high
    cycle(1'b0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    for (int i = 0; i < 13; i++) cycle(1'b0, 1'b1, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    cycle(1'b0, 1'b1, 1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    check("backpressure_next_accepted", busy, 1);
    idle(10);

    // Reset during CAPTURE of byte 2 discards the operation
    res_before = n_res;
    cycle(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1, '0, '0, 1'b0);
    idle(15);
    check("reset_no_result", n_res, res_before);

    // Signed overflow boundary cases
    cycle(1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    idle(10);
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    idle(10);

    // Back-to-back operations with in_valid held high
    res_before = n_res;
    cycle(1'b0, 1'b1, 1'b1, 32'h89AB_CDEF, 32'h7654_3210, 1'b0);
    for (int i = 0; i < 19; i++) cycle(1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, '0, '0, 1'b0);
    check("back_to_back_results", n_res - res_before, 2);
    idle(2);

    // Randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : 32'($urandom);
      cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) != 0), ra, rb, 1'($urandom_range(0, 1)));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
